hyperram_req_adapter: RTL and testbench



---
 rtl/hyperram_req_adapter.sv | 217 +++++++++++++++++++++
 tb/tb_hyperram_req_adapter.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hyperram_req_adapter.sv
// hyperram_req_adapter
// Host-side front end for hyperbus_interface. Takes one halfword-oriented
// read or write request at a time, builds the 48-bit HyperBus CA packet and
// holds it with the burst length and timing configuration until completion.
// Write bursts are fully buffered before the PHY is started so the byte
// stream can never starve. Halfwords go down as bytes, high byte first.
// Returned bytes are packed back into halfwords.
//
// Ports
//   clk, rst                      system clock, synchronous active-high reset
//   req_vld/req_rdy               request handshake (accept = vld & rdy)
//   req_write, req_reg            direction, register/memory space select
//   req_addr, req_len             halfword address and halfword count
//   cfg_latency/recovery/shmoo    timing configuration, latched at accept
//   wr_data/wr_vld/wr_rdy         write halfword stream (only taken in FILL)
//   rd_data/rd_vld                read halfwords, no backpressure
//   done                          one-cycle completion pulse
//   hb_*                          1:1 connection to hyperbus_interface
module hyperram_req_adapter #(
    parameter int W_BURSTLEN = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_vld,
    output logic                  req_rdy,
    input  logic                  req_write,
    input  logic                  req_reg,
    input  logic [31:0]           req_addr,
    input  logic [W_BURSTLEN-1:0] req_len,
    input  logic [3:0]            cfg_latency,
    input  logic [3:0]            cfg_recovery,
    input  logic [1:0]            cfg_shmoo,
    input  logic [15:0]           wr_data,
    input  logic                  wr_vld,
    output logic                  wr_rdy,
    output logic [15:0]           rd_data,
    output logic                  rd_vld,
    output logic                  done,
    output logic [47:0]           hb_cmd_addr,
    output logic                  hb_start_reg,
    output logic                  hb_start_data,
    input  logic                  hb_start_rdy,
    output logic [W_BURSTLEN-1:0] hb_burst_len,
    output logic [3:0]            hb_latency,
    output logic [3:0]            hb_recovery,
    output logic [1:0]            hb_capture_shmoo,
    output logic [7:0]            hb_wdata,
    input  logic                  hb_wdata_rdy,
    input  logic [7:0]            hb_rdata,
    input  logic                  hb_rdata_vld
);

    localparam int DEPTH = 1 << W_BURSTLEN;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_ISSUE,
        ST_XFER,
        ST_FIN
    } state_t;

    state_t                state_reg, state_next;
    logic [47:0]           cmd_addr_reg;
    logic [W_BURSTLEN-1:0] burst_len_reg;
    logic [3:0]            latency_reg;
    logic [3:0]            recovery_reg;
    logic [1:0]            shmoo_reg;
    logic                  is_write_reg;
    logic                  is_reg_reg;
    // One bit wider than the length so a full-size burst never wraps.
    logic [W_BURSTLEN:0]   hw_cnt_reg;
    logic                  byte_phase_reg;
    logic [7:0]            hi_reg;
    logic [15:0]           rd_data_reg;
    logic                  rd_vld_reg;

    logic [15:0]           wbuf [DEPTH];
    logic [15:0]           buf_word;

    logic                  accept;
    logic                  wr_take;
    logic                  start_fire;
    logic                  cnt_full;
    logic                  wr_xfer;
    logic                  byte_step;
    logic                  rd_byte;
    logic [W_BURSTLEN:0]   len_ext;

    // Handshakes and strobes are masked by rst so nothing leaks out in the
    // reset cycle itself, whatever state the register still holds.
    assign len_ext    = {1'b0, burst_len_reg};
    assign cnt_full   = (hw_cnt_reg == len_ext);
    assign req_rdy    = (state_reg == ST_IDLE) && !rst;
    assign wr_rdy     = (state_reg == ST_FILL) && !rst;
    assign done       = (state_reg == ST_FIN) && !rst;
    assign accept     = req_vld && req_rdy;
    assign wr_take    = wr_vld && wr_rdy;
    assign start_fire = (state_reg == ST_ISSUE) && hb_start_rdy && !rst;
    assign wr_xfer    = (state_reg == ST_XFER) && is_write_reg && !cnt_full;
    assign byte_step  = wr_xfer && hb_wdata_rdy;
    assign rd_byte    = (state_reg == ST_XFER) && !is_write_reg && !cnt_full && hb_rdata_vld;

    assign hb_start_data = start_fire && !is_reg_reg;
    assign hb_start_reg  = start_fire && is_reg_reg;

    // Write bytes come straight from the buffer; the halfword counter is the
    // read index and byte_phase_reg selects high byte first.
    assign buf_word = wbuf[hw_cnt_reg[W_BURSTLEN-1:0]];
    assign hb_wdata = wr_xfer ? (byte_phase_reg ? buf_word[7:0] : buf_word[15:8]) : 8'h00;

    assign hb_cmd_addr      = cmd_addr_reg;
    assign hb_burst_len     = burst_len_reg;
    assign hb_latency       = latency_reg;
    assign hb_recovery      = recovery_reg;
    assign hb_capture_shmoo = shmoo_reg;
    assign rd_data          = rd_data_reg;
    assign rd_vld           = rd_vld_reg;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    if (req_len == '0)
                        state_next = ST_FIN;
                    else if (req_write)
                        state_next = ST_FILL;
                    else
                        state_next = ST_ISSUE;
                end
            end
            ST_FILL: begin
                if (wr_take && ((hw_cnt_reg + 1'b1) == len_ext))
                    state_next = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (start_fire)
                    state_next = ST_XFER;
            end
            ST_XFER: begin
                // The PHY drops start_rdy while busy; its return marks the
                // end of the bus transaction.
                if (cnt_full && hb_start_rdy)
                    state_next = ST_FIN;
            end
            ST_FIN:  state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            cmd_addr_reg   <= '0;
            burst_len_reg  <= '0;
            latency_reg    <= '0;
            recovery_reg   <= '0;
            shmoo_reg      <= '0;
            is_write_reg   <= 1'b0;
            is_reg_reg     <= 1'b0;
            hw_cnt_reg     <= '0;
            byte_phase_reg <= 1'b0;
            hi_reg         <= '0;
            rd_data_reg    <= '0;
            rd_vld_reg     <= 1'b0;
        end else begin
            state_reg  <= state_next;
            rd_vld_reg <= rd_byte && byte_phase_reg;

            if (accept) begin
                cmd_addr_reg   <= {!req_write, req_reg, 1'b1, req_addr[31:3], 13'd0, req_addr[2:0]};
                burst_len_reg  <= req_len;
                latency_reg    <= cfg_latency;
                recovery_reg   <= cfg_recovery;
                shmoo_reg      <= cfg_shmoo;
                is_write_reg   <= req_write;
                is_reg_reg     <= req_reg;
                hw_cnt_reg     <= '0;
                byte_phase_reg <= 1'b0;
            end

            if (wr_take)
                hw_cnt_reg <= hw_cnt_reg + 1'b1;

            // The counter is reused as the transfer index once issued.
            if (state_reg == ST_ISSUE) begin
                hw_cnt_reg     <= '0;
                byte_phase_reg <= 1'b0;
            end

            if (byte_step) begin
                byte_phase_reg <= !byte_phase_reg;
                if (byte_phase_reg)
                    hw_cnt_reg <= hw_cnt_reg + 1'b1;
            end

            if (rd_byte) begin
                byte_phase_reg <= !byte_phase_reg;
                if (!byte_phase_reg) begin
                    hi_reg <= hb_rdata;
                end else begin
                    rd_data_reg <= {hi_reg, hb_rdata};
                    hw_cnt_reg  <= hw_cnt_reg + 1'b1;
                end
            end
        end
    end

    // Buffer storage has no reset: a reset clears the counter, which makes
    // any stale contents unreachable.
    always_ff @(posedge clk) begin
        if (wr_take)
            wbuf[hw_cnt_reg[W_BURSTLEN-1:0]] <= wr_data;
    end

endmodule

// File: tb/tb_hyperram_req_adapter.sv
// Directed bench for hyperram_req_adapter with a small behavioural PHY that
// accepts start strobes, consumes/produces bytes and logs what it sees.
module tb_hyperram_req_adapter;

    localparam int W = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_vld = 1'b0, req_write = 1'b0, req_reg = 1'b0;
    logic [31:0]   req_addr = '0;
    logic [W-1:0]  req_len = '0;
    logic [3:0]    cfg_latency = '0, cfg_recovery = '0;
    logic [1:0]    cfg_shmoo = '0;
    logic [15:0]   wr_data = '0;
    logic          wr_vld = 1'b0;
    logic          req_rdy, wr_rdy, rd_vld, done;
    logic [15:0]   rd_data;
    logic [47:0]   hb_cmd_addr;
    logic          hb_start_reg, hb_start_data;
    logic          hb_start_rdy = 1'b1;
    logic [W-1:0]  hb_burst_len;
    logic [3:0]    hb_latency, hb_recovery;
    logic [1:0]    hb_capture_shmoo;
    logic [7:0]    hb_wdata;
    logic          hb_wdata_rdy = 1'b0;
    logic [7:0]    hb_rdata = '0;
    logic          hb_rdata_vld = 1'b0;

    hyperram_req_adapter #(.W_BURSTLEN(W)) dut (
        .clk(clk), .rst(rst),
        .req_vld(req_vld), .req_rdy(req_rdy), .req_write(req_write), .req_reg(req_reg),
        .req_addr(req_addr), .req_len(req_len),
        .cfg_latency(cfg_latency), .cfg_recovery(cfg_recovery), .cfg_shmoo(cfg_shmoo),
        .wr_data(wr_data), .wr_vld(wr_vld), .wr_rdy(wr_rdy),
        .rd_data(rd_data), .rd_vld(rd_vld), .done(done),
        .hb_cmd_addr(hb_cmd_addr), .hb_start_reg(hb_start_reg), .hb_start_data(hb_start_data),
        .hb_start_rdy(hb_start_rdy), .hb_burst_len(hb_burst_len),
        .hb_latency(hb_latency), .hb_recovery(hb_recovery), .hb_capture_shmoo(hb_capture_shmoo),
        .hb_wdata(hb_wdata), .hb_wdata_rdy(hb_wdata_rdy),
        .hb_rdata(hb_rdata), .hb_rdata_vld(hb_rdata_vld)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- PHY model and logs ----------------
    bit          start_seen = 0, phy_busy = 0, phy_dir_wr = 0, phy_rd_gap = 0;
    int          phy_cnt = 0, phy_total = 0, recov = 0, phy_byte_limit = 1000;
    int          rdy_back_cyc = -1;
    logic [7:0]  rd_src[$];
    logic [7:0]  wbytes[$];
    logic [15:0] rd_q[$];
    int          rd_cyc_q[$], pair_cyc_q[$], done_cyc_q[$];
    int          n_st_data = 0, n_st_reg = 0, st_cyc = -1, done_cnt = 0;

    // Inputs change on the falling edge; outputs are observed 1 time unit
    // later, i.e. exactly what the next rising edge will act on.
    always begin
        @(negedge clk);
        if (rst) begin
            start_seen   = 0;
            phy_busy     = 0;
            recov        = 0;
            phy_cnt      = 0;
            hb_start_rdy = 1'b1;
            hb_wdata_rdy = 1'b0;
            hb_rdata_vld = 1'b0;
        end else begin
            if (start_seen) begin
                start_seen   = 0;
                hb_start_rdy = 1'b0;
                phy_busy     = 1;
                phy_cnt      = 0;
            end
            if (phy_busy && phy_cnt >= phy_total) begin
                phy_busy     = 0;
                recov        = 2;
                hb_wdata_rdy = 1'b0;
                hb_rdata_vld = 1'b0;
            end else if (phy_busy) begin
                if (phy_dir_wr)
                    hb_wdata_rdy = ($urandom_range(0, 3) != 0);
                else if (phy_cnt < phy_byte_limit && rd_src.size() > 0 &&
                         (!phy_rd_gap || $urandom_range(0, 2) != 0)) begin
                    hb_rdata     = rd_src.pop_front();
                    hb_rdata_vld = 1'b1;
                end else
                    hb_rdata_vld = 1'b0;
            end else if (recov > 0) begin
                recov--;
                if (recov == 0) begin
                    hb_start_rdy = 1'b1;
                    rdy_back_cyc = cyc;
                end
            end
        end
        #1;
        if (hb_start_data) begin n_st_data++; st_cyc = cyc; end
        if (hb_start_reg)  begin n_st_reg++;  st_cyc = cyc; end
        if ((hb_start_data || hb_start_reg) && hb_start_rdy && !rst) begin
            start_seen = 1;
            phy_total  = 2 * int'(hb_burst_len);
            phy_dir_wr = !hb_cmd_addr[47];
        end
        if (done) begin done_cnt++; done_cyc_q.push_back(cyc); end
        if (rd_vld) begin rd_q.push_back(rd_data); rd_cyc_q.push_back(cyc); end
        if (phy_busy && phy_dir_wr && hb_wdata_rdy) begin
            wbytes.push_back(hb_wdata);
            phy_cnt++;
        end
        if (phy_busy && !phy_dir_wr && hb_rdata_vld) begin
            phy_cnt++;
            if (phy_cnt % 2 == 0) pair_cyc_q.push_back(cyc);
        end
    end

    function automatic logic [15:0] rd_at(input int i);
        if (i < rd_q.size()) return rd_q[i];
        return 16'hxxxx;
    endfunction

    function automatic logic [7:0] wb_at(input int i);
        if (i < wbytes.size()) return wbytes[i];
        return 8'hxx;
    endfunction

    function automatic int icq(input int q[$], input int i);
        if (i >= 0 && i < q.size()) return q[i];
        return -99;
    endfunction

    task automatic clear_logs();
        wbytes.delete(); rd_q.delete(); rd_cyc_q.delete(); pair_cyc_q.delete(); done_cyc_q.delete();
        n_st_data = 0; n_st_reg = 0; st_cyc = -1;
    endtask

    // ---------------- host-side tasks ----------------
    logic [15:0] wr_src [32];

    // Returns at the falling edge of the cycle after accept; request fields
    // are then scrambled so held values are really latched copies.
    task automatic do_req(input logic w, input logic r, input logic [31:0] a, input logic [W-1:0] l,
                          input logic [3:0] lat, input logic [3:0] rec, input logic [1:0] shm,
                          output int acc);
        bit ok;
        ok = 0;
        acc = -1;
        req_write = w; req_reg = r; req_addr = a; req_len = l;
        cfg_latency = lat; cfg_recovery = rec; cfg_shmoo = shm;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clk);
            req_vld = 1'b1;
            #1;
            if (req_rdy) begin ok = 1; acc = cyc; end
        end
        check("req_accept", ok, 1);
        @(negedge clk);
        req_vld = 1'b0;
        req_write = ~w; req_reg = ~r; req_addr = ~a; req_len = ~l;
        cfg_latency = ~lat; cfg_recovery = ~rec; cfg_shmoo = ~shm;
    endtask

    task automatic feed_wr(input int n, input bit gapped, output int last_take);
        bit taken;
        last_take = -1;
        for (int i = 0; i < n; i++) begin
            taken = 0;
            if (gapped)
                repeat ((i % 3) + 1) begin @(negedge clk); wr_vld = 1'b0; end
            for (int t = 0; t < 100 && !taken; t++) begin
                @(negedge clk);
                wr_vld  = 1'b1;
                wr_data = wr_src[i];
                #1;
                if (wr_rdy) begin taken = 1; last_take = cyc; end
            end
            check("wr_take", taken, 1);
        end
        @(negedge clk);
        wr_vld  = 1'b0;
        wr_data = '0;
    endtask

    task automatic wait_done(input int target, input string tag);
        bit ok;
        ok = 0;
        for (int i = 0; i < 600 && !ok; i++) begin
            @(negedge clk);
            #2;
            if (done_cnt >= target) ok = 1;
        end
        check(tag, ok, 1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    // ---------------- directed tests ----------------
    initial begin
        int acc, acc2, last, tgt, rdn, dn;
        bit ok;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check("rst_req_rdy", req_rdy, 0);
        check("rst_ctl", {wr_rdy, rd_vld, done, hb_start_data, hb_start_reg}, 0);
        check("rst_ca_len", {hb_cmd_addr, hb_burst_len}, 0);
        check("rst_cfg_data", {hb_latency, hb_recovery, hb_capture_shmoo, rd_data, hb_wdata}, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rel_req_rdy", req_rdy, 1);
        #1;

        // Read, memory space, addr 0x1234, len 2, gapped bytes
        clear_logs();
        rd_src = {8'hAB, 8'hCD, 8'hEF, 8'h01};
        phy_rd_gap = 1;
        tgt = done_cnt + 1;
        do_req(1'b0, 1'b0, 32'h0000_1234, 5'd2, 4'd6, 4'd3, 2'd2, acc);
        #1;
        check("rd_ca", hb_cmd_addr, 48'hA000_0246_0004);
        check("rd_len", hb_burst_len, 2);
        check("rd_cfg", {hb_latency, hb_recovery, hb_capture_shmoo}, {4'd6, 4'd3, 2'd2});
        check("rd_start_now", {hb_start_data, hb_start_reg}, 2'b10);
        wait_done(tgt, "rd_done_seen");
        check("rd_n_start", {n_st_data[7:0], n_st_reg[7:0]}, 16'h0100);
        check("rd_start_lat", st_cyc, acc + 1);
        check("rd_count", rd_q.size(), 2);
        check("rd_hw0", rd_at(0), 16'hABCD);
        check("rd_hw1", rd_at(1), 16'hEF01);
        check("rd_vld_lat", icq(rd_cyc_q, 0), icq(pair_cyc_q, 0) + 1);
        check("rd_vld_lat2", icq(rd_cyc_q, 1), icq(pair_cyc_q, 1) + 1);
        check("rd_done_lat", icq(done_cyc_q, 0), rdy_back_cyc + 1);

        // Write, addr 0x10, len 3, gapped wr_vld, random wdata_rdy stalls
        clear_logs();
        wr_src[0] = 16'h1122; wr_src[1] = 16'h3344; wr_src[2] = 16'h5566;
        tgt = done_cnt + 1;
        do_req(1'b1, 1'b0, 32'h0000_0010, 5'd3, 4'd4, 4'd2, 2'd1, acc);
        #1;
        check("wr_ca", hb_cmd_addr, 48'h2000_0002_0000);
        check("wr_rdy_fill", wr_rdy, 1);
        feed_wr(3, 1'b1, last);
        #1;
        check("wr_rdy_drop", wr_rdy, 0);
        check("wr_start_now", hb_start_data, 1);
        wait_done(tgt, "wr_done_seen");
        check("wr_n_start", {n_st_data[7:0], n_st_reg[7:0]}, 16'h0100);
        check("wr_start_lat", st_cyc, last + 1);
        check("wr_nbytes", wbytes.size(), 6);
        for (int i = 0; i < 6; i++)
            check("wr_byte", wb_at(i), (i % 2 == 0) ? wr_src[i / 2][15:8] : wr_src[i / 2][7:0]);

        // Register write, addr 0x800, len 1
        clear_logs();
        wr_src[0] = 16'hBEEF;
        tgt = done_cnt + 1;
        do_req(1'b1, 1'b1, 32'h0000_0800, 5'd1, 4'd1, 4'd1, 2'd0, acc);
        #1;
        check("reg_ca", hb_cmd_addr, 48'h6000_0100_0000);
        feed_wr(1, 1'b0, last);
        wait_done(tgt, "reg_done_seen");
        check("reg_n_start", {n_st_data[7:0], n_st_reg[7:0]}, 16'h0001);
        check("reg_bytes", {wb_at(0), wb_at(1), wbytes.size()[7:0]}, {8'hBE, 8'hEF, 8'd2});

        // Zero length
        clear_logs();
        do_req(1'b0, 1'b0, 32'h0000_0040, 5'd0, 4'd0, 4'd0, 2'd0, acc);
        #1;
        check("zero_done", done, 1);
        check("zero_no_strobe", {hb_start_data, hb_start_reg}, 0);
        @(negedge clk);
        #1;
        check("zero_rdy_after", {req_rdy, done}, 2'b10);
        repeat (3) @(negedge clk);
        #2;
        check("zero_no_start", n_st_data + n_st_reg, 0);

        // Maximum length write, then a read queued behind it
        clear_logs();
        for (int i = 0; i < 31; i++) wr_src[i] = 16'(i * 291 + 16384);
        for (int k = 0; k < 62; k++) rd_src.push_back(8'(k * 7 + 3));
        phy_rd_gap = 0;
        tgt = done_cnt + 1;
        do_req(1'b1, 1'b0, 32'h0000_2000, 5'd31, 4'd7, 4'd5, 2'd3, acc);
        fork
            feed_wr(31, 1'b0, last);
            do_req(1'b0, 1'b0, 32'h0000_3000, 5'd31, 4'd7, 4'd5, 2'd3, acc2);
        join
        #1;
        check("max_rd_len", {hb_cmd_addr[47], hb_burst_len}, {1'b1, 5'd31});
        check("max_b2b", acc2, icq(done_cyc_q, 0) + 1);
        wait_done(tgt + 1, "max_rd_done_seen");
        check("max_wr_nbytes", wbytes.size(), 62);
        for (int i = 0; i < 62; i++)
            check("max_wr_byte", wb_at(i), (i % 2 == 0) ? wr_src[i / 2][15:8] : wr_src[i / 2][7:0]);
        check("max_rd_count", rd_q.size(), 31);
        for (int j = 0; j < 31; j++)
            check("max_rd_hw", rd_at(j), {8'(2 * j * 7 + 3), 8'((2 * j + 1) * 7 + 3)});
        check("max_rd_spacing", icq(rd_cyc_q, 1) - icq(rd_cyc_q, 0), 2);

        // Reset in the middle of a read, after 3 bytes
        clear_logs();
        rd_src = {8'h11, 8'h22, 8'h33, 8'h44};
        phy_byte_limit = 3;
        do_req(1'b0, 1'b0, 32'h0000_0100, 5'd2, 4'd2, 4'd2, 2'd1, acc);
        ok = 0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            #2;
            if (phy_cnt >= 3) ok = 1;
        end
        check("rst_mid_bytes", ok, 1);
        repeat (2) @(negedge clk);
        #2;
        rdn = rd_q.size();
        dn  = done_cnt;
        check("rst_mid_pair", {rdn[7:0], rd_at(0)}, {8'd1, 16'h1122});
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_mid_quiet", {req_rdy, done, hb_start_data, hb_start_reg, wr_rdy}, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        phy_byte_limit = 1000;
        rd_src.delete();
        #1;
        check("rst_mid_rdy", req_rdy, 1);
        repeat (5) @(negedge clk);
        #2;
        check("rst_mid_no_rd", rd_q.size(), rdn);
        check("rst_mid_no_done", done_cnt, dn);
        rd_src = {8'h5A, 8'hA5};
        tgt = done_cnt + 1;
        do_req(1'b0, 1'b0, 32'h0000_0200, 5'd1, 4'd2, 4'd2, 2'd1, acc);
        wait_done(tgt, "rst_after_done_seen");
        check("rst_after_count", rd_q.size(), rdn + 1);
        check("rst_after_hw", rd_at(rd_q.size() - 1), 16'h5AA5);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
